// File: rtl/act_skew_feeder_pkg.sv
// Shared constants and types for the systolic array front end.
// Feeder FSM encoding lives here so every stage agrees on it.
package act_skew_feeder_pkg;

  localparam int SYSTOLIC_SIZE     = 8;
  localparam int ACTIVATION_WIDTH  = 8;
  localparam int WEIGHT_WIDTH      = 8;
  localparam int PARTIAL_SUM_WIDTH = 32;
  localparam int FIFO_DEPTH        = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2
  } feed_state_e;

  // Entry count needs one extra bit so "full" is representable.
  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/act_fifo.sv
// Small synchronous FIFO holding {last, vector} entries.
// Pointers wrap naturally because DEPTH is a power of two.
module act_fifo
  import act_skew_feeder_pkg::*;
#(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = fifo_cnt_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Pointers and occupancy; simultaneous push/pop keeps count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/act_skew_feeder.sv
// Buffers activation vectors and skews them diagonally:
// row r lags row 0 by r cycles; idle lanes present zero.
module act_skew_feeder #(
  parameter int SYSTOLIC_SIZE    =
    act_skew_feeder_pkg::SYSTOLIC_SIZE,
  parameter int ACTIVATION_WIDTH =
    act_skew_feeder_pkg::ACTIVATION_WIDTH,
  parameter int FIFO_DEPTH       =
    act_skew_feeder_pkg::FIFO_DEPTH
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic in_last,
  input  logic [SYSTOLIC_SIZE*ACTIVATION_WIDTH-1:0] in_data,
  output logic [SYSTOLIC_SIZE*ACTIVATION_WIDTH-1:0] act_out,
  output logic [SYSTOLIC_SIZE-1:0] act_valid,
  output logic busy,
  output logic done
);

  import act_skew_feeder_pkg::*;

  localparam int AW   = ACTIVATION_WIDTH;
  localparam int LW   = SYSTOLIC_SIZE * AW;
  localparam int CNTW = $clog2(SYSTOLIC_SIZE);

  feed_state_e     state_q;
  logic [CNTW-1:0] drain_cnt_q;
  logic            done_q;

  logic [LW:0]     fifo_rdata;
  logic            fifo_full;
  logic            fifo_empty;
  logic            pop;
  logic            head_last;
  logic [LW-1:0]   head_data;

  logic            s0_valid_q;
  logic [LW-1:0]   s0_data_q;

  logic [SYSTOLIC_SIZE-1:0] row_v;
  logic [LW-1:0]            row_d;

  act_fifo #(
    .WIDTH (LW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .wdata ({in_last, in_data}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign in_ready  = !fifo_full;
  assign head_last = fifo_rdata[LW];
  assign head_data = fifo_rdata[LW-1:0];
  assign pop       = (state_q == ST_FEED) && !fifo_empty;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;

  // Stream control: feed until a last entry pops, then drain
  // so the final vector walks the full diagonal before done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      drain_cnt_q <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state_q <= ST_FEED;
          end
        end
        ST_FEED: begin
          if (pop && head_last) begin
            state_q     <= ST_DRAIN;
            drain_cnt_q <= CNTW'(SYSTOLIC_SIZE - 1);
          end
        end
        ST_DRAIN: begin
          if (drain_cnt_q == '0) begin
            state_q <= ST_IDLE;
          end else begin
            drain_cnt_q <= drain_cnt_q - CNTW'(1);
            if (drain_cnt_q == CNTW'(1)) begin
              done_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Stage 0 captures the popped head, or a zero bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_valid_q <= 1'b0;
      s0_data_q  <= '0;
    end else begin
      s0_valid_q <= pop;
      s0_data_q  <= pop ? head_data : '0;
    end
  end

  // Skew triangle: lane r passes through r extra registers.
  for (genvar r = 0; r < SYSTOLIC_SIZE; r++) begin : g_row
    if (r == 0) begin : g_direct
      assign row_v[0]      = s0_valid_q;
      assign row_d[0 +: AW] = s0_data_q[0 +: AW];
    end else begin : g_delay
      logic [AW-1:0] dly_q [r];
      logic [r-1:0]  vld_q;

      // Shift this lane's value and valid down its chain.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_q <= '0;
          for (int k = 0; k < r; k++) begin
            dly_q[k] <= '0;
          end
        end else begin
          vld_q[0] <= s0_valid_q;
          dly_q[0] <= s0_data_q[r*AW +: AW];
          for (int k = 1; k < r; k++) begin
            vld_q[k] <= vld_q[k-1];
            dly_q[k] <= dly_q[k-1];
          end
        end
      end

      assign row_v[r]        = vld_q[r-1];
      assign row_d[r*AW +: AW] = dly_q[r-1];
    end

    assign act_valid[r] = row_v[r];
    assign act_out[r*AW +: AW] =
      row_v[r] ? row_d[r*AW +: AW] : '0;
  end

endmodule

// File: tb/tb_act_skew_feeder.sv
// Self-checking bench for act_skew_feeder.
// Diagonal scoreboard plus directed timing sequences.
module tb_act_skew_feeder;

  localparam int S  = 8;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int LW = S * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          in_last;
  logic [LW-1:0] in_data;
  logic [LW-1:0] act_out;
  logic [S-1:0]  act_valid;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  act_skew_feeder #(
    .SYSTOLIC_SIZE    (S),
    .ACTIVATION_WIDTH (W),
    .FIFO_DEPTH       (D)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .in_data   (in_data),
    .act_out   (act_out),
    .act_valid (act_valid),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    logic [LW-1:0] d;
    logic          last;
    int            seq;
    int            gap;
  } vec_t;

  typedef struct {
    logic         v;
    logic [S-1:0] av;
    logic         dn;
    logic         bz;
  } row_t;

  vec_t exp_q[$];
  vec_t pend[$];
  int   shown_cyc[int];
  int   acc_cyc[int];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   seq_n = 0;
  int   done_cnt = 0;
  int   done_cyc = -1;
  int   ready_lo = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [LW-1:0] act,
                     input logic [LW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mkvec(input logic last,
                                 input int gap);
    vec_t v;
    v.d    = {$urandom, $urandom};
    v.last = last;
    v.seq  = seq_n;
    v.gap  = gap;
    seq_n++;
    return v;
  endfunction

  // Reference: each accepted vector appears on row 0 in order;
  // row r at cycle t shows lane r of what row 0 had at t-r.
  initial begin : mon
    vec_t          h[S];
    bit            hv[S];
    logic [LW-1:0] eo;
    logic [S-1:0]  ev;
    logic          ed;
    forever begin
      @(posedge clk);
      #2;
      if (!mon_en || rst) begin
        for (int r = 0; r < S; r++) hv[r] = 1'b0;
        continue;
      end
      for (int r = S - 1; r > 0; r--) begin
        hv[r] = hv[r-1];
        h[r]  = h[r-1];
      end
      hv[0] = 1'b0;
      if (act_valid[0]) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL row0_extra: got valid want none");
        end else begin
          h[0]  = exp_q.pop_front();
          hv[0] = 1'b1;
          shown_cyc[h[0].seq] = cyc;
        end
      end
      ev = '0;
      eo = '0;
      for (int r = 0; r < S; r++) begin
        if (hv[r]) begin
          ev[r]          = 1'b1;
          eo[r*W +: W]   = h[r].d[r*W +: W];
        end
      end
      ed = hv[S-1] && h[S-1].last;
      chk("act_valid", LW'(act_valid), LW'(ev));
      chk("act_out", act_out, eo);
      chk("done", LW'(done), LW'(ed));
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic step(input logic v, input logic l,
                      input logic [LW-1:0] d,
                      output bit acc);
    in_valid = v;
    in_last  = l;
    in_data  = d;
    acc = v && in_ready;
    if (v && !in_ready) ready_lo++;
    @(posedge clk);
    #1;
  endtask

  task automatic send();
    bit   acc;
    vec_t v;
    int   n;
    while (pend.size() > 0) begin
      v = pend.pop_front();
      repeat (v.gap) step(1'b0, 1'b0, '0, acc);
      n   = 0;
      acc = 1'b0;
      while (!acc) begin
        step(1'b1, v.last, v.d, acc);
        n++;
        if (!acc && n > 100) begin
          total++;
          bad++;
          $display("FAIL push_timeout: seq %0d", v.seq);
          break;
        end
      end
      if (acc) begin
        exp_q.push_back(v);
        acc_cyc[v.seq] = cyc;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic flush(output int fall);
    bit acc;
    int n = 0;
    while (!(exp_q.size() == 0 && !busy) && n < 300) begin
      step(1'b0, 1'b0, '0, acc);
      n++;
    end
    fall = cyc;
    chk("flushed", LW'(exp_q.size()), '0);
  endtask

  row_t tbl[12];

  initial begin : wdog
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit            acc;
    int            fall;
    int            d0;
    int            s0;
    int            ls;
    int            n;
    logic [LW-1:0] pat;
    logic [LW-1:0] eo;
    vec_t          v;

    tbl[0]  = '{1'b1, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 8'h01, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 8'h02, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 8'h04, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 8'h08, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 8'h10, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 8'h20, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 8'h40, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 8'h80, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0};

    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    rst      = 1'b1;
    #22;
    chk("rst_act_valid", LW'(act_valid), '0);
    chk("rst_act_out", act_out, '0);
    chk("rst_busy", LW'(busy), '0);
    chk("rst_done", LW'(done), '0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_ready", LW'(in_ready), LW'(1));
    mon_en = 1'b1;

    // Single vector, lanes r+1, exact diagonal timing.
    for (int r = 0; r < S; r++) pat[r*W +: W] = W'(r + 1);
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].v, tbl[i].v, pat, acc);
      if (acc) begin
        v = '{pat, 1'b1, seq_n, 0};
        seq_n++;
        exp_q.push_back(v);
      end
      eo = '0;
      for (int r = 0; r < S; r++)
        if (tbl[i].av[r]) eo[r*W +: W] = pat[r*W +: W];
      chk("t1_valid", LW'(act_valid), LW'(tbl[i].av));
      chk("t1_out", act_out, eo);
      chk("t1_done", LW'(done), LW'(tbl[i].dn));
      chk("t1_busy", LW'(busy), LW'(tbl[i].bz));
      chk("t1_ready", LW'(in_ready), LW'(1));
    end

    // Eight back-to-back vectors, all lanes = k.
    d0 = done_cnt;
    s0 = seq_n;
    for (int k = 1; k <= 8; k++) begin
      v = mkvec(k == 8, 0);
      v.d = {S{8'(k)}};
      pend.push_back(v);
    end
    send();
    flush(fall);
    chk("t2_nogap",
        LW'(shown_cyc[s0+7] - shown_cyc[s0]), LW'(7));
    chk("t2_done_at",
        LW'(done_cyc - shown_cyc[s0+7]), LW'(S - 1));
    chk("t2_busy_fall", LW'(fall - done_cyc), LW'(1));
    chk("t2_done_cnt", LW'(done_cnt - d0), LW'(1));

    // Stream B queued while stream A drains.
    d0 = done_cnt;
    s0 = seq_n;
    ready_lo = 0;
    pend.push_back(mkvec(1'b0, 0));
    pend.push_back(mkvec(1'b1, 0));
    for (int k = 0; k < 5; k++)
      pend.push_back(mkvec(k == 4, 0));
    send();
    flush(fall);
    chk("t3_backpressure", LW'(ready_lo > 0), LW'(1));
    chk("t3_four_held",
        LW'(acc_cyc[s0+5] < shown_cyc[s0+2]), LW'(1));
    chk("t3_fifth_wait",
        LW'(acc_cyc[s0+6] >= shown_cyc[s0+2]), LW'(1));
    chk("t3_done_cnt", LW'(done_cnt - d0), LW'(2));

    // Input gap mid-stream gives a 2-cycle bubble.
    d0 = done_cnt;
    s0 = seq_n;
    pend.push_back(mkvec(1'b0, 0));
    pend.push_back(mkvec(1'b0, 3));
    pend.push_back(mkvec(1'b0, 0));
    pend.push_back(mkvec(1'b0, 2));
    pend.push_back(mkvec(1'b0, 0));
    pend.push_back(mkvec(1'b1, 0));
    send();
    flush(fall);
    chk("t4_lean",
        LW'(shown_cyc[s0+2] - shown_cyc[s0+1]), LW'(1));
    chk("t4_bubble",
        LW'(shown_cyc[s0+3] - shown_cyc[s0+2]), LW'(3));
    chk("t4_done_cnt", LW'(done_cnt - d0), LW'(1));

    // Full FIFO with push+pop; order across pointer wrap.
    d0 = done_cnt;
    ready_lo = 0;
    pend.push_back(mkvec(1'b1, 0));
    s0 = seq_n;
    for (int k = 0; k < 12; k++)
      pend.push_back(mkvec(k == 11, 0));
    send();
    flush(fall);
    chk("t6_full_seen", LW'(ready_lo > 0), LW'(1));
    chk("t6_rate",
        LW'(shown_cyc[s0+11] - shown_cyc[s0]), LW'(11));
    chk("t6_done_cnt", LW'(done_cnt - d0), LW'(2));

    // Asynchronous reset in the middle of DRAIN.
    for (int k = 0; k < 3; k++)
      pend.push_back(mkvec(k == 2, 0));
    ls = seq_n - 1;
    send();
    n = 0;
    while (!shown_cyc.exists(ls) && n < 50) begin
      step(1'b0, 1'b0, '0, acc);
      n++;
    end
    repeat (3) step(1'b0, 1'b0, '0, acc);
    chk("t5_in_drain", LW'(busy), LW'(1));
    mon_en = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk("t5_act_valid", LW'(act_valid), '0);
    chk("t5_act_out", act_out, '0);
    chk("t5_busy", LW'(busy), '0);
    chk("t5_done", LW'(done), '0);
    @(posedge clk);
    #4;
    rst = 1'b0;
    #1;
    chk("t5_ready", LW'(in_ready), LW'(1));
    exp_q.delete();
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b0, '0, acc);
      chk("t5_no_done", LW'(done), '0);
      chk("t5_quiet", LW'(act_valid), '0);
    end
    mon_en = 1'b1;

    // Random streams against the diagonal scoreboard.
    d0 = done_cnt;
    for (int st = 0; st < 20; st++) begin
      n = $urandom_range(1, 6);
      for (int j = 0; j < n; j++)
        pend.push_back(mkvec(j == n - 1,
                             $urandom_range(0, 3)));
    end
    send();
    flush(fall);
    chk("rnd_done_cnt", LW'(done_cnt - d0), LW'(20));
    chk("rnd_idle", LW'(busy), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
